// File: rtl/tr_pkg.sv
// Shared types for the traffic phase controller: light codes and FSM states.
package tr_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_EMG     = 2'd3
    } state_t;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: DIV must be >= 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase controller with density-stretched greens and
// an emergency all-red override.
module traffic_phase_ctrl
    import tr_pkg::*;
#(
    parameter int NUM_DIR   = 2,
    parameter int TICK_DIV  = 100_000_000,
    parameter int CNT_W     = 6,
    parameter int GREEN_LO  = 10,
    parameter int GREEN_HI  = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    localparam int DIR_W    = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DIR-1:0]   density_sel,
    input  logic                 emg,
    output logic [2*NUM_DIR-1:0] light_o,
    output logic [DIR_W-1:0]     active_dir,
    output logic [CNT_W-1:0]     remain_sec,
    output logic                 heavy_o,
    output logic                 phase_valid
);

    localparam int DUR_MAX = 2 ** CNT_W;

    if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
        $error("traffic_phase_ctrl: NUM_DIR must be in 2..4");
    end
    if (GREEN_LO < 1 || GREEN_LO >= DUR_MAX || GREEN_HI < 1 || GREEN_HI >= DUR_MAX ||
        YELLOW_T < 1 || YELLOW_T >= DUR_MAX || ALL_RED_T < 1 || ALL_RED_T >= DUR_MAX)
    begin : g_bad_duration
        $error("traffic_phase_ctrl: durations must be in 1..2**CNT_W-1");
    end

    logic tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst_n  (reset),
        .tick_o (tick)
    );

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       remain_q, remain_d;
    logic [DIR_W-1:0]       dir_q, dir_d, next_dir;
    logic                   heavy_q, heavy_d;
    logic [2*NUM_DIR-1:0]   light_q, light_d;
    logic                   pv_q, pv_d;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        heavy_d  = heavy_q;
        next_dir = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);

        // Emergency wins over everything, including a phase expiring this cycle.
        if (emg) begin
            state_d  = S_EMG;
            remain_d = '0;
        end else if (state_q == S_EMG) begin
            state_d  = S_ALL_RED;
            remain_d = CNT_W'(ALL_RED_T);
        end else if (tick) begin
            if (remain_q == CNT_W'(1)) begin
                case (state_q)
                    S_ALL_RED: begin
                        state_d  = S_GREEN;
                        dir_d    = next_dir;
                        heavy_d  = density_sel[next_dir];
                        remain_d = density_sel[next_dir] ? CNT_W'(GREEN_HI) : CNT_W'(GREEN_LO);
                    end
                    S_GREEN: begin
                        state_d  = S_YELLOW;
                        remain_d = CNT_W'(YELLOW_T);
                    end
                    S_YELLOW: begin
                        state_d  = S_ALL_RED;
                        remain_d = CNT_W'(ALL_RED_T);
                    end
                    default: ;
                endcase
            end else if (remain_q > CNT_W'(1)) begin
                remain_d = remain_q - CNT_W'(1);
            end
        end

        // Lights are decoded from the next state so they register alongside it.
        light_d = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            light_d[2*i +: 2] = RED;
            if (dir_d == DIR_W'(i)) begin
                if (state_d == S_GREEN) begin
                    light_d[2*i +: 2] = GREEN;
                end else if (state_d == S_YELLOW) begin
                    light_d[2*i +: 2] = YELLOW;
                end
            end
        end

        pv_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_ALL_RED;
            remain_q <= CNT_W'(ALL_RED_T);
            dir_q    <= DIR_W'(NUM_DIR - 1);
            heavy_q  <= 1'b0;
            light_q  <= '0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
            heavy_q  <= heavy_d;
            light_q  <= light_d;
            pv_q     <= pv_d;
        end
    end

    assign light_o     = light_q;
    assign active_dir  = dir_q;
    assign remain_sec  = remain_q;
    assign heavy_o     = heavy_q;
    assign phase_valid = pv_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a phase-level reference model.
module tb_traffic_phase_ctrl;

    localparam int NDIR  = 3;
    localparam int TDIV  = 4;
    localparam int G_LO  = 10;
    localparam int G_HI  = 30;
    localparam int Y_T   = 3;
    localparam int AR_T  = 2;

    localparam int PH_RED = 0;
    localparam int PH_GRN = 1;
    localparam int PH_YEL = 2;
    localparam int PH_EMG = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NDIR-1:0] density_sel = '0;
    logic            emg = 1'b0;
    logic [2*NDIR-1:0] light_o;
    logic [1:0]      active_dir;
    logic [5:0]      remain_sec;
    logic            heavy_o;
    logic            phase_valid;

    int checks = 0;
    int errors = 0;
    int pv_seen = 0;

    int m_pre, m_ph, m_rem, m_dir, m_heavy, m_pv;

    traffic_phase_ctrl #(
        .NUM_DIR(NDIR), .TICK_DIV(TDIV), .CNT_W(6),
        .GREEN_LO(G_LO), .GREEN_HI(G_HI), .YELLOW_T(Y_T), .ALL_RED_T(AR_T)
    ) dut (
        .clk(clk), .reset(reset), .density_sel(density_sel), .emg(emg),
        .light_o(light_o), .active_dir(active_dir), .remain_sec(remain_sec),
        .heavy_o(heavy_o), .phase_valid(phase_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_ph = PH_RED; m_rem = AR_T; m_dir = NDIR - 1; m_heavy = 0; m_pv = 0;
    endtask

    // One second elapses at every TDIV-th edge; phases expire when a tick hits 1 s left.
    task automatic model_edge(input logic e, input logic [NDIR-1:0] d);
        int prev;
        bit tk;
        tk = (m_pre == TDIV - 1);
        m_pre = (m_pre + 1) % TDIV;
        prev = m_ph;
        if (e) begin
            m_ph = PH_EMG; m_rem = 0;
        end else if (m_ph == PH_EMG) begin
            m_ph = PH_RED; m_rem = AR_T;
        end else if (tk) begin
            if (m_rem > 1) m_rem = m_rem - 1;
            else if (m_ph == PH_RED) begin
                m_dir = (m_dir + 1) % NDIR;
                m_heavy = d[m_dir];
                m_rem = m_heavy ? G_HI : G_LO;
                m_ph = PH_GRN;
            end else if (m_ph == PH_GRN) begin
                m_ph = PH_YEL; m_rem = Y_T;
            end else begin
                m_ph = PH_RED; m_rem = AR_T;
            end
        end
        m_pv = (m_ph != prev);
    endtask

    function automatic logic [2*NDIR-1:0] exp_light();
        logic [2*NDIR-1:0] v;
        v = '0;
        if (m_ph == PH_GRN) v[2*m_dir +: 2] = 2'd1;
        else if (m_ph == PH_YEL) v[2*m_dir +: 2] = 2'd2;
        return v;
    endfunction

    task automatic check_model();
        chk("light_o", 32'(light_o), 32'(exp_light()));
        chk("active_dir", 32'(active_dir), 32'(m_dir));
        chk("remain_sec", 32'(remain_sec), 32'(m_rem));
        chk("heavy_o", 32'(heavy_o), 32'(m_heavy));
        chk("phase_valid", 32'(phase_valid), 32'(m_pv));
        if (phase_valid === 1'b1) pv_seen++;
    endtask

    task automatic cyc(input logic e, input logic [NDIR-1:0] d);
        emg = e;
        density_sel = d;
        @(posedge clk);
        model_edge(e, d);
        #2;
        check_model();
    endtask

    task automatic run_until(input int ph, input int dir, input int budget, input logic [NDIR-1:0] d);
        int n;
        n = 0;
        while (!(m_ph == ph && (dir < 0 || m_dir == dir)) && n < budget) begin
            cyc(1'b0, d);
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_light"}, 32'(light_o), 32'd0);
        chk({tag, "_remain"}, 32'(remain_sec), 32'(AR_T));
        chk({tag, "_dir"}, 32'(active_dir), 32'(NDIR - 1));
        chk({tag, "_heavy"}, 32'(heavy_o), 32'd0);
        chk({tag, "_pv"}, 32'(phase_valid), 32'd0);
    endtask

    initial begin
        // Asynchronous reset before the first clock edge.
        #1 reset = 1'b0;
        #1 check_reset_values("rst0");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Idle with no density: first green is dir0 at the low duration.
        pv_seen = 0;
        run_until(PH_GRN, 0, 40, 3'b000);
        chk("first_green_light", 32'(light_o), 32'b000001);
        chk("first_green_remain", 32'(remain_sec), 32'(G_LO));
        chk("first_green_heavy", 32'(heavy_o), 32'd0);
        chk("first_green_dir", 32'(active_dir), 32'd0);
        chk("first_green_pv_count", 32'(pv_seen), 32'd1);

        // Heavy flag on dir1: long green, then yellow, all-red and a short dir2 green.
        run_until(PH_GRN, 1, 300, 3'b010);
        chk("dir1_heavy_remain", 32'(remain_sec), 32'(G_HI));
        chk("dir1_heavy_flag", 32'(heavy_o), 32'd1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 3'(i & 1) << 1);
        chk("dir1_toggle_heavy", 32'(heavy_o), 32'd1);
        run_until(PH_GRN, 2, 300, 3'b010);
        chk("dir2_remain", 32'(remain_sec), 32'(G_LO));
        chk("dir2_light", 32'(light_o), 32'b010000);

        // Emergency during dir1 green; interrupted direction is skipped.
        run_until(PH_GRN, 1, 400, 3'b000);
        for (int i = 0; i < 6; i++) cyc(1'b0, 3'b000);
        cyc(1'b1, 3'b000);
        chk("emg_light", 32'(light_o), 32'd0);
        chk("emg_remain", 32'(remain_sec), 32'd0);
        cyc(1'b1, 3'b000);
        chk("emg_hold_pv", 32'(phase_valid), 32'd0);
        cyc(1'b0, 3'b000);
        chk("emg_exit_remain", 32'(remain_sec), 32'(AR_T));
        run_until(PH_GRN, -1, 40, 3'b000);
        chk("after_emg_dir", 32'(active_dir), 32'd2);

        // Emergency coincident with a yellow expiry.
        run_until(PH_YEL, -1, 400, 3'b000);
        while (!(m_ph == PH_YEL && m_rem == 1 && m_pre == TDIV - 1)) cyc(1'b0, 3'b000);
        pv_seen = 0;
        cyc(1'b1, 3'b000);
        chk("emg_yel_light", 32'(light_o), 32'd0);
        chk("emg_yel_remain", 32'(remain_sec), 32'd0);
        cyc(1'b1, 3'b000);
        cyc(1'b1, 3'b000);
        chk("emg_yel_pv_count", 32'(pv_seen), 32'd1);
        cyc(1'b0, 3'b000);

        // Asynchronous reset in the middle of a yellow.
        run_until(PH_YEL, -1, 400, 3'b000);
        cyc(1'b0, 3'b000);
        #1 reset = 1'b0;
        #1 check_reset_values("rst_mid");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        run_until(PH_GRN, -1, 40, 3'b000);
        chk("rst_mid_next_dir", 32'(active_dir), 32'd0);

        // Randomized density and sporadic emergency bursts.
        for (int i = 0; i < 3000; i++) begin
            logic e;
            e = ($urandom_range(0, 299) == 0) || (emg && $urandom_range(0, 2) != 0);
            cyc(e, 3'($urandom));
        end

        // Emergency held across reset release goes straight to S_EMG.
        emg = 1'b1;
        #1 reset = 1'b0;
        #1 check_reset_values("rst_emg");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1'b1, 3'b000);
        chk("rst_emg_pv", 32'(phase_valid), 32'd1);
        for (int i = 0; i < 60; i++) cyc(1'b0, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 2: number of approach directions served round-robin, legal range 2..4.
REQ-002 SHALL have parameter TICK_DIV, default 100_000_000: clk cycles per one-second tick, legal values >= 2.
REQ-003 SHALL have parameter CNT_W, default 6: width of the seconds countdown.
REQ-004 SHALL have parameters GREEN_LO=10, GREEN_HI=30, YELLOW_T=3, ALL_RED_T=2: phase durations in seconds, each in 1..2**CNT_W-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port density_sel, input, NUM_DIR bits: per-direction heavy-flow flag from video processing.
REQ-008 SHALL have port emg, input, 1 bit: emergency request forcing all directions red.
REQ-009 SHALL have port light_o, output, 2*NUM_DIR bits: per-direction light code, RED=0, GREEN=1, YELLOW=2.
REQ-010 SHALL have port active_dir, output, DIR_W = max(1, clog2(NUM_DIR)) bits: direction currently owning green/yellow.
REQ-011 SHALL have port remain_sec, output, CNT_W bits: seconds left in the current phase.
REQ-012 SHALL have port heavy_o, output, 1 bit: density flag sampled for the current green.
REQ-013 SHALL have port phase_valid, output, 1 bit: one-cycle pulse following every state change.

Function
REQ-014 SHALL generate an internal tick: free-running prescaler 0..TICK_DIV-1, tick high for one cycle when the count equals TICK_DIV-1.
REQ-015 SHALL implement FSM states S_ALL_RED, S_GREEN, S_YELLOW and S_EMG.
REQ-016 In S_ALL_RED, when tick and remain_sec==1, the FSM SHALL go to S_GREEN, advance active_dir by 1 (wrapping NUM_DIR-1 to 0), sample density_sel[new dir] into heavy_o, and load remain_sec with GREEN_HI if the flag is set, else GREEN_LO.
REQ-017 In S_GREEN, when tick and remain_sec==1, the FSM SHALL go to S_YELLOW and load YELLOW_T.
REQ-018 In S_YELLOW, when tick and remain_sec==1, the FSM SHALL go to S_ALL_RED and load ALL_RED_T.
REQ-019 On a tick with remain_sec>1 and no transition, remain_sec SHALL decrement by 1; without a tick it SHALL hold.
REQ-020 density_sel SHALL be sampled only at green entry; changes during a green SHALL NOT alter remain_sec or heavy_o.
REQ-021 light_o SHALL drive GREEN (S_GREEN) or YELLOW (S_YELLOW) for active_dir, and RED for every other direction; all directions SHALL be RED in S_ALL_RED and S_EMG.
REQ-022 When emg is high in any state, the next cycle SHALL enter S_EMG, with all lights RED and remain_sec=0; emg SHALL take priority over a simultaneous tick expiry.
REQ-023 In S_EMG with emg low, the next cycle SHALL enter S_ALL_RED and load ALL_RED_T; active_dir SHALL be unchanged, so the interrupted direction is skipped.
REQ-024 phase_valid SHALL be high exactly on the cycle after each state register change, and low otherwise, including while S_EMG is held.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for a clock edge, set: state=S_ALL_RED, remain_sec=ALL_RED_T, active_dir=NUM_DIR-1, all light_o RED, heavy_o=0, phase_valid=0, prescaler=0; the first green after reset is therefore direction 0.
REQ-027 Reset deasserted mid-phase SHALL discard all phase progress; emg high at release SHALL enter S_EMG on the first clock.

Structure
REQ-028 A shared package tr_pkg SHALL hold the light code enum (RED/GREEN/YELLOW) and the FSM state enum.
REQ-029 The prescaler SHALL be a sub-module tick_gen, parameterised by DIV.
REQ-030 Elaboration checks SHALL reject any duration >= 2**CNT_W or equal to 0, and any NUM_DIR outside 2..4.

Verification (TICK_DIV=4, NUM_DIR=3, default durations)
REQ-031 Reset then idle, density_sel=0 -> after 2 ticks dir0 GREEN, remain_sec=10, heavy_o=0; dir1/dir2 RED; phase_valid pulses once.
REQ-032 density_sel=3'b010 -> dir1 green lasts 30 ticks, then YELLOW for 3 ticks, then ALL_RED for 2 ticks, then dir2 GREEN with 10 ticks.
REQ-033 density_sel toggled mid-green on the active direction -> remain_sec and heavy_o are unaffected.
REQ-034 emg pulsed during dir1 GREEN -> all RED the next cycle and remain_sec=0; after release, ALL_RED for 2 ticks, then dir2 GREEN.
REQ-035 emg asserted on the same cycle as a yellow expiry -> S_EMG is entered, not S_ALL_RED; phase_valid pulses exactly once.
REQ-036 Reset asserted mid-yellow, asynchronously between clock edges -> outputs take their reset values immediately; dir0 is the next green.
